// File: rtl/ring_pkg.sv
// Purpose : shared types and constants for the 4-bit ring counter decoder.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
package ring_pkg;

   localparam int RING_W = 4;

   // Tracking states; ACQUIRE and FAULT both relock on the next one-hot sample.
   typedef enum logic [1:0] {
      ACQUIRE = 2'd0,
      LOCKED  = 2'd1,
      FAULT   = 2'd2
   } state_t;

   // One-hot ring values for phases 0..3, written as ring[0:3].
   localparam logic [0:RING_W-1] PH0_HOT = 4'b0001;
   localparam logic [0:RING_W-1] PH1_HOT = 4'b1000;
   localparam logic [0:RING_W-1] PH2_HOT = 4'b0100;
   localparam logic [0:RING_W-1] PH3_HOT = 4'b0010;

   // Expected successor phase; wraps 3 -> 0 through the 2-bit width.
   function automatic logic [1:0] next_phase(input logic [1:0] p);
      return p + 2'd1;
   endfunction

endpackage

// File: rtl/ring_phase_enc.sv
// Purpose : maps a sampled ring value to {is_onehot, phase}.
// Latency : combinational, zero cycles.
// Backpressure: none; pure function of ring.
// Ports   : ring[0:3] in; is_onehot out (1 = legal one-hot value);
//           phase[1:0] out (valid only when is_onehot is 1, else 0).
module ring_phase_enc
   import ring_pkg::*;
(
   input  logic [0:RING_W-1] ring,
   output logic              is_onehot,
   output logic [1:0]        phase
);

   always_comb begin
      is_onehot = 1'b1;
      phase     = 2'd0;
      case (ring)
         PH0_HOT: phase = 2'd0;
         PH1_HOT: phase = 2'd1;
         PH2_HOT: phase = 2'd2;
         PH3_HOT: phase = 2'd3;
         default: is_onehot = 1'b0;
      endcase
   end

endmodule

// File: rtl/ring_decoder_4_bit.sv
// Purpose : tracks a 4-bit ring counter, reports phase, lock, errors, revolutions.
// Latency : 2 cycles; inputs registered at edge N, outputs reflect them after N+1.
// Backpressure: none; one sample accepted every clock.
// Ports   : clk, rst (async active-low); ring[0:3], ring_rst in;
//           phase, locked, onehot_err, seq_err, rev_cnt[REV_W-1:0] out.
module ring_decoder_4_bit
   import ring_pkg::*;
#(
   parameter int REV_W = 8
)(
   input  logic              clk,
   input  logic              rst,
   input  logic [0:RING_W-1] ring,
   input  logic              ring_rst,
   output logic [1:0]        phase,
   output logic              locked,
   output logic              onehot_err,
   output logic              seq_err,
   output logic [REV_W-1:0]  rev_cnt
);

   localparam logic [REV_W-1:0] REV_ONE = {{(REV_W-1){1'b0}}, 1'b1};

   // Input sample stage. smp_vld stays low until the first edge after reset so
   // the cleared sample register is never judged as an illegal ring value.
   logic [0:RING_W-1] smp_ring;
   logic              smp_rst;
   logic              smp_vld;

   logic              enc_onehot;
   logic [1:0]        enc_phase;

   state_t            state_q;
   state_t            state_d;
   logic [1:0]        phase_d;
   logic              onehot_err_d;
   logic              seq_err_d;
   logic              rev_inc;

   ring_phase_enc u_enc (
      .ring      (smp_ring),
      .is_onehot (enc_onehot),
      .phase     (enc_phase)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         smp_ring <= '0;
         smp_rst  <= 1'b0;
         smp_vld  <= 1'b0;
      end else begin
         smp_ring <= ring;
         smp_rst  <= ring_rst;
         smp_vld  <= 1'b1;
      end
   end

   always_comb begin
      state_d      = state_q;
      phase_d      = phase;
      onehot_err_d = 1'b0;
      seq_err_d    = 1'b0;
      rev_inc      = 1'b0;
      if (smp_vld) begin
         if (smp_rst && (smp_ring == PH0_HOT)) begin
            // Ring reset to phase 0 is legal from anywhere and is not a revolution.
            state_d = LOCKED;
            phase_d = 2'd0;
         end else if (!enc_onehot) begin
            // Phase is held; only a locked tracker drops into FAULT.
            onehot_err_d = 1'b1;
            if (state_q == LOCKED) begin
               state_d = FAULT;
            end
         end else if (smp_rst) begin
            // Ring reset landing anywhere but phase 0 is a sequence error, but
            // the new phase is still the best estimate of where the ring is.
            seq_err_d = 1'b1;
            phase_d   = enc_phase;
            state_d   = LOCKED;
         end else begin
            case (state_q)
               LOCKED: begin
                  phase_d = enc_phase;
                  if (enc_phase != next_phase(phase)) begin
                     seq_err_d = 1'b1;
                  end else if (phase == 2'd3) begin
                     rev_inc = 1'b1;
                  end
               end
               default: begin
                  // ACQUIRE and FAULT relock directly with no sequence check.
                  phase_d = enc_phase;
                  state_d = LOCKED;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ACQUIRE;
         phase      <= 2'd0;
         onehot_err <= 1'b0;
         seq_err    <= 1'b0;
         rev_cnt    <= '0;
      end else begin
         state_q    <= state_d;
         phase      <= phase_d;
         onehot_err <= onehot_err_d;
         seq_err    <= seq_err_d;
         if (rev_inc && (rev_cnt != '1)) begin
            rev_cnt <= rev_cnt + REV_ONE;
         end
      end
   end

   assign locked = (state_q == LOCKED);

endmodule

// File: tb/tb_ring_decoder_4_bit.sv
module tb_ring_decoder_4_bit;

   localparam int REV_W   = 2;
   localparam int REV_MAX = (1 << REV_W) - 1;

   logic             clk;
   logic             rst;
   logic [0:3]       ring;
   logic             ring_rst;
   logic [1:0]       phase;
   logic             locked;
   logic             onehot_err;
   logic             seq_err;
   logic [REV_W-1:0] rev_cnt;

   int tests = 0;
   int fails = 0;
   logic cmp_en = 1'b0;

   ring_decoder_4_bit #(.REV_W(REV_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .ring       (ring),
      .ring_rst   (ring_rst),
      .phase      (phase),
      .locked     (locked),
      .onehot_err (onehot_err),
      .seq_err    (seq_err),
      .rev_cnt    (rev_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // The ring sequence as an ordered list; a value's position is its phase.
   logic [3:0] legal [0:3] = '{4'b0001, 4'b1000, 4'b0100, 4'b0010};

   int   m_phase;
   bit   m_locked;
   bit   m_oh;
   bit   m_seq;
   int   m_rev;
   bit   m_vld;
   logic [3:0] m_ring;
   bit   m_rr;

   function automatic int pos_of(input logic [3:0] r);
      int p = -1;
      for (int i = 0; i < 4; i++) if (legal[i] == r) p = i;
      return p;
   endfunction

   task automatic model_eval(input logic [3:0] r, input bit rr);
      int idx = pos_of(r);
      m_oh  = 0;
      m_seq = 0;
      if (rr && r == 4'b0001) begin
         m_locked = 1; m_phase = 0;
      end else if (idx < 0) begin
         m_oh = 1; m_locked = 0;
      end else if (rr) begin
         m_seq = 1; m_phase = idx; m_locked = 1;
      end else if (m_locked) begin
         if (idx != (m_phase + 1) % 4) m_seq = 1;
         else if (m_phase == 3 && m_rev < REV_MAX) m_rev++;
         m_phase = idx;
      end else begin
         m_phase = idx; m_locked = 1;
      end
   endtask

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_phase = 0; m_locked = 0; m_oh = 0; m_seq = 0; m_rev = 0;
         m_vld = 0; m_ring = 4'b0000; m_rr = 0;
      end else begin
         if (m_vld) model_eval(m_ring, m_rr);
         m_ring = ring;
         m_rr   = ring_rst;
         m_vld  = 1;
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("cyc_phase",      int'(phase),      m_phase);
         chk("cyc_locked",     int'(locked),     int'(m_locked));
         chk("cyc_onehot_err", int'(onehot_err), int'(m_oh));
         chk("cyc_seq_err",    int'(seq_err),    int'(m_seq));
         chk("cyc_rev_cnt",    int'(rev_cnt),    m_rev);
      end
   end

   // ---------------- directed stimulus ----------------
   // Applies a sample, waits for the edge that registers it, returns 1 ns after.
   task automatic step(input logic [3:0] r, input logic rr);
      ring     = r;
      ring_rst = rr;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst      = 1'b0;
      ring     = 4'b0000;
      ring_rst = 1'b0;
      @(posedge clk);
      cmp_en = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_locked",  int'(locked),  0);
      chk("rst_phase",   int'(phase),   0);
      chk("rst_rev_cnt", int'(rev_cnt), 0);
      rst = 1'b1;

      // Illegal sample in ACQUIRE, then one clean revolution.
      step(4'b0011, 0);
      step(4'b0001, 0);
      chk("acq_onehot_err", int'(onehot_err), 1);
      chk("acq_locked",     int'(locked),     0);
      step(4'b1000, 0);
      chk("lock_2cyc_locked", int'(locked), 1);
      chk("lock_2cyc_phase",  int'(phase),  0);
      step(4'b0100, 0);
      chk("seq_phase1", int'(phase), 1);
      step(4'b0010, 0);
      chk("seq_phase2", int'(phase), 2);
      step(4'b0001, 0);
      chk("seq_phase3", int'(phase), 3);
      step(4'b1000, 0);
      chk("rev1_phase", int'(phase),   0);
      chk("rev1_cnt",   int'(rev_cnt), 1);

      // Phase 1 followed by phase-3 value: sequence error.
      step(4'b0010, 0);
      chk("pre_skip_phase", int'(phase), 1);
      step(4'b0001, 0);
      chk("skip_seq_err", int'(seq_err), 1);
      chk("skip_phase",   int'(phase),   3);
      chk("skip_locked",  int'(locked),  1);
      step(4'b1000, 0);
      chk("skip_seq_clr", int'(seq_err), 0);
      chk("rev2_cnt",     int'(rev_cnt), 2);

      // Non-one-hot while locked, then relock at phase 2.
      step(4'b1100, 0);
      step(4'b0100, 0);
      chk("fault_onehot_err", int'(onehot_err), 1);
      chk("fault_locked",     int'(locked),     0);
      chk("fault_phase_held", int'(phase),      1);
      // Ring reset to phase 0 evaluated against phase 2.
      step(4'b0001, 1);
      chk("relock_locked", int'(locked),  1);
      chk("relock_phase",  int'(phase),   2);
      chk("relock_seq",    int'(seq_err), 0);
      step(4'b1000, 0);
      chk("rrst_phase",  int'(phase),      0);
      chk("rrst_seq",    int'(seq_err),    0);
      chk("rrst_oh",     int'(onehot_err), 0);
      chk("rrst_rev",    int'(rev_cnt),    2);

      // Ring reset with wrong values: one-hot and non-one-hot.
      step(4'b0100, 1);
      step(4'b0000, 1);
      chk("rrst_bad_seq", int'(seq_err), 1);
      step(4'b0001, 1);
      chk("rrst_bad_oh",  int'(onehot_err), 1);

      // Five full revolutions saturate the 2-bit counter.
      for (int n = 0; n < 5; n++) begin
         step(4'b1000, 0);
         step(4'b0100, 0);
         step(4'b0010, 0);
         step(4'b0001, 0);
      end
      step(4'b1000, 0);
      chk("sat_rev_cnt", int'(rev_cnt), 3);
      chk("sat_locked",  int'(locked),  1);

      // Asynchronous reset between edges while locked.
      @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      chk("arst_phase",  int'(phase),      0);
      chk("arst_locked", int'(locked),     0);
      chk("arst_oh",     int'(onehot_err), 0);
      chk("arst_seq",    int'(seq_err),    0);
      chk("arst_rev",    int'(rev_cnt),    0);
      ring = 4'b0100;
      @(posedge clk);
      #1;
      rst = 1'b1;
      step(4'b0100, 0);
      chk("post_rst_unlocked", int'(locked), 0);
      step(4'b0010, 0);
      chk("post_rst_locked", int'(locked),     1);
      chk("post_rst_phase",  int'(phase),      2);
      chk("post_rst_seq",    int'(seq_err),    0);
      chk("post_rst_oh",     int'(onehot_err), 0);
      step(4'b0001, 0);
      chk("post_rst_next", int'(phase), 3);

      @(posedge clk);
      #1;
      cmp_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
